// File: rtl/stage1_log2_approx.sv
`default_nettype none
// ============================================================================
// Module      : stage1_log2_approx
// Description : Registered Mitchell log2 of a Q4.12 operand, with both
//               operands forwarded alongside the result.
// Revision    : 1.0 - initial release
// ============================================================================
module stage1_log2_approx #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  output logic              valid_out,
  output logic [DATA_W-1:0] log_in_0,
  output logic [DATA_W-1:0] in_0_bypass,
  output logic [DATA_W-1:0] in_1_bypass
);

  localparam logic [DATA_W-1:0] c_LOG_MIN = 16'h8000;

  logic [3:0]        w_p;
  logic [3:0]        w_shift;
  logic [DATA_W-1:0] w_m;
  logic [11:0]       w_frac;
  logic [4:0]        w_k;
  logic              w_sat;
  logic [DATA_W-1:0] w_log;

  logic              r_valid;
  logic [DATA_W-1:0] r_log;
  logic [DATA_W-1:0] r_b0;
  logic [DATA_W-1:0] r_b1;

  // Leading-one detector over the magnitude bits; later hits overwrite earlier.
  always_comb begin
    w_p = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (in_0[i]) w_p = 4'(i);
    end
  end

  assign w_shift = 4'd15 - w_p;
  assign w_m     = in_0 << w_shift;
  assign w_frac  = w_m[14:3];
  assign w_k     = {1'b0, w_p} - 5'd12;

  // Zero, negative and sub-2^-8 inputs all clamp to -8.0.
  assign w_sat = in_0[DATA_W-1] || (in_0 == '0) || (w_p < 4'd4);
  assign w_log = w_sat ? c_LOG_MIN
                       : ({w_k[3:0], 12'h000} + {4'h0, w_frac});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_log   <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
    end else if (en) begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_log <= w_log;
        r_b0  <= in_0;
        r_b1  <= in_1;
      end
    end
  end

  assign valid_out   = r_valid;
  assign log_in_0    = r_log;
  assign in_0_bypass = r_b0;
  assign in_1_bypass = r_b1;

endmodule
`default_nettype wire

// File: tb/tb_stage1_log2_approx.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage1_log2_approx
// Description : Scoreboard bench for stage1_log2_approx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage1_log2_approx;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [15:0] in_0;
  logic [15:0] in_1;
  logic        valid_out;
  logic [15:0] log_in_0;
  logic [15:0] in_0_bypass;
  logic [15:0] in_1_bypass;

  exp_t q[$];
  exp_t last;
  logic exp_valid;
  int   n_pass = 0;
  int   n_total = 0;

  stage1_log2_approx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .valid_in   (valid_in),
    .in_0       (in_0),
    .in_1       (in_1),
    .valid_out  (valid_out),
    .log_in_0   (log_in_0),
    .in_0_bypass(in_0_bypass),
    .in_1_bypass(in_1_bypass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Arithmetic reference: log2 ~ k + (x - 2^k)/2^k, truncated to 12 bits.
  function automatic logic [15:0] ref_log(input logic [15:0] x);
    int p;
    int frac;
    int res;
    if (x[15] || x == 16'h0) return 16'h8000;
    p = 14;
    while (((int'(x) >> p) & 1) == 0) p--;
    if (p < 4) return 16'h8000;
    frac = ((int'(x) - (1 << p)) * 4096) >> p;
    res  = (p - 12) * 4096 + frac;
    return res[15:0];
  endfunction

  // One cycle: drive on falling edge, check 1 time unit after the rising edge.
  task automatic step(input logic e, input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_l);
    @(negedge clk);
    en = e; valid_in = v; in_0 = a; in_1 = b;
    if (e && v) q.push_back('{l: exp_l, a: a, b: b});
    @(posedge clk);
    #1;
    if (e) exp_valid = v;
    if (e && v) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty got=none exp=entry");
      end else last = q.pop_front();
    end
    chk("valid_out", {15'h0, valid_out}, {15'h0, exp_valid});
    chk("log_in_0", log_in_0, last.l);
    chk("in_0_bypass", in_0_bypass, last.a);
    chk("in_1_bypass", in_1_bypass, last.b);
  endtask

  logic [15:0] pin  [6]  = '{16'h0040, 16'h0100, 16'h0400, 16'h1000, 16'h2000, 16'h4000};
  logic [15:0] pexp [6]  = '{16'hA000, 16'hC000, 16'hE000, 16'h0000, 16'h1000, 16'h2000};
  logic [15:0] din  [10] = '{16'h00C0, 16'h0140, 16'h2400, 16'h5000, 16'h3C00,
                             16'h0000, 16'h8001, 16'h000F, 16'h0010, 16'h0018};
  logic [15:0] dexp [10] = '{16'hB800, 16'hC400, 16'h1200, 16'h2400, 16'h1E00,
                             16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8800};

  initial begin
    rst = 1'b1; en = 1'b1; valid_in = 1'b1; in_0 = 16'h1234; in_1 = 16'h5678;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", {15'h0, valid_out}, 16'h0);
    chk("rst_log", log_in_0, 16'h0);
    chk("rst_b0", in_0_bypass, 16'h0);
    chk("rst_b1", in_1_bypass, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    last = '0;
    exp_valid = 1'b0;

    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, pin[i], 16'h0040, pexp[i]);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, din[i], 16'hBEEF ^ 16'(i), dexp[i]);

    // Stall: accept A, then three frozen cycles, then next sample.
    step(1'b1, 1'b1, 16'h2400, 16'h1111, 16'h1200);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h4000 + 16'(i), 16'h2222, 16'h0);
    step(1'b1, 1'b1, 16'h5000, 16'h3333, 16'h2400);

    // Valid gating: one pulse then idle with changing data.
    step(1'b1, 1'b1, 16'h0100, 16'h4444, 16'hC000);
    step(1'b1, 1'b0, 16'h3C00, 16'h5555, 16'h0);
    step(1'b1, 1'b0, 16'h0018, 16'h6666, 16'h0);

    for (int i = 0; i < 300; i++) begin
      logic        e;
      logic        v;
      logic [15:0] a;
      e = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 3) != 0);
      a = 16'($urandom);
      if (i % 3 == 0) a = a >> $urandom_range(0, 15);
      step(e, v, a, 16'($urandom), ref_log(a));
    end

    // Reset mid-stream with en=1 and valid_in=1 has priority.
    @(negedge clk);
    rst = 1'b1; en = 1'b1; valid_in = 1'b1; in_0 = 16'h2000;
    @(posedge clk);
    #1;
    chk("rst2_valid", {15'h0, valid_out}, 16'h0);
    chk("rst2_log", log_in_0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage1_log2_approx.md
Name: stage1_log2_approx

Overview:
- First pipeline stage of the log-domain softmax datapath.
- Computes a piecewise-linear (Mitchell) base-2 logarithm of the Q4.12 operand in_0.
- Forwards both raw operands, in_0 and in_1, so that downstream stages see them aligned with the log result.
- One registered stage: 1-cycle latency, with a valid flag and a stall enable.

Parameters:
- DATA_W, 16, width of every data port (fixed-point word).
- FRAC_W, 12, fractional bits of the Q4.12 format. The implementation only needs to support the defaults.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  pipeline enable; 0 = stall (all registers hold)
- valid_in  input  1  in_0/in_1 carry a valid sample this cycle
- in_0  input  16  Q4.12 operand to take log2 of (sum term)
- in_1  input  16  Q4.12 operand passed through unchanged
- valid_out  output  1  registered valid, aligned with the data outputs
- log_in_0  output  16  signed Q4.12 approx log2(in_0)
- in_0_bypass  output  16  registered copy of in_0
- in_1_bypass  output  16  registered copy of in_1

Behaviour:
- All outputs are registered and update on the rising edge of clk. No combinational path exists from inputs to outputs.
- Reset: when rst=1 at an edge, valid_out=0, log_in_0=0x0000, in_0_bypass=0x0000, in_1_bypass=0x0000. rst has priority over en and valid_in.
- en=0: every register holds, including valid_out.
- en=1: valid_out <= valid_in.
- en=1 and valid_in=1: log_in_0 <= f(in_0), in_0_bypass <= in_0, in_1_bypass <= in_1.
- en=1 and valid_in=0: data registers hold their previous value; only valid_out changes.
- Latency: exactly 1 cycle, so a sample accepted at edge N is visible after edge N.
- Throughput: 1 sample per cycle.
- Definition of f(x), with x taken as a signed Q4.12 value:
  - Zero or negative: if x[15]=1 or x=0, f = 0x8000 (-8.0, saturated minimum).
  - Leading-one search: otherwise p = index of the most significant 1 in x[14:0] (0..14), and k = p - 12 (range -12..2).
  - Normalisation: m = x << (15 - p), 16 bits, so m[15]=1. Fraction frac = m[14:3], 12 bits; bits shifted out below are truncated, and zeros are shifted in.
  - Result: f = (k << 12) + frac, formed in 16-bit two's complement. The integer part is k and the fraction is frac, giving log2(x) ≈ k + (x/2^k - 1).
  - Saturation: if k < -8 (p < 4, i.e. x < 0x0010), f = 0x8000.
  - Maximum: the largest result is 0x7FFF-range input -> k=2, frac≈0.999 -> ~2.9998. No positive overflow is possible.
- Exactness: f is exact (equals true log2) at powers of two. Elsewhere the error is at most ~0.086, the Mitchell bound, always underestimating.
- Combinational logic is one 15-bit leading-one detector, one barrel shifter and one adder. No multipliers or LUTs.
- Pass-through values are bit-exact; in_1 is never interpreted.

Test Plan:
- Reset: drive rst=1 for 1 cycle with en=1 and valid_in=1 -> after the edge, all outputs are 0 and valid_out=0.
- Power-of-two inputs: in_0 = 0x0040, 0x0100, 0x0400, 0x1000, 0x2000, 0x4000 with in_1=0x0040, valid_in=1, en=1.
  - log_in_0 after 1 edge = 0xA000 (-6), 0xC000 (-4), 0xE000 (-2), 0x0000 (0), 0x1000 (1), 0x2000 (2).
  - in_0_bypass equals in_0; in_1_bypass = 0x0040; valid_out=1.
- Mantissa interpolation:
  - in_0=0x00C0 -> 0xB800 (-4.5).
  - in_0=0x0140 -> 0xC400 (-3.75).
  - in_0=0x2400 -> 0x1200 (1.125).
  - in_0=0x5000 -> 0x2400 (2.25).
  - in_0=0x3C00 -> 0x1E00 (1.875).
- Edge cases:
  - in_0=0x0000 -> 0x8000.
  - in_0=0x8001 (negative) -> 0x8000.
  - in_0=0x000F (k<-8) -> 0x8000.
  - in_0=0x0010 -> 0x8000 (k=-8, frac 0).
  - in_0=0x0018 -> 0x8800.
- Stall: sample A accepted, then en=0 for 3 cycles while in_0 changes and valid_in=1 -> outputs and valid_out frozen at A's values. On en=1 the next sample is captured 1 edge later.
- Valid gating: valid_in pulse for 1 cycle, then valid_in=0 with new in_0 -> valid_out goes 1 for one cycle, then 0. Data outputs keep the pulsed sample's values.
